// File: rtl/mem_dump_ctrl.sv
// Memory read-back engine: streams LEN bytes from BASE out of a data_mem-style port.
// One read in flight at a time; per-byte period RD_LAT+2 cycles; OUT holds until dout_ready.
module mem_dump_ctrl #(
  parameter int AW     = 12,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  input  logic          abort,
  output logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_rdata,
  output logic          m_rd,
  output logic          m_wr,
  output logic          m_en,
  output logic [DW-1:0] dout_data,
  output logic [AW-1:0] dout_addr,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT, S_DONE} state_t;

  localparam logic [AW:0]   REM_ONE  = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [2:0]    W_ONE    = 3'd1;
  localparam logic [2:0]    W_INIT   = 3'(RD_LAT);

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [AW:0]   rem;
  logic [2:0]    wcnt;
  logic          abort_pend;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (length == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wcnt == W_ONE) state_nxt = S_OUT;
      // An abort arriving in the handshake cycle itself still ends the dump here.
      S_OUT:   if (dout_ready)
                 state_nxt = (rem == REM_ONE || abort_pend || abort) ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    m_en       = 1'b0;
    m_rd       = 1'b0;
    m_addr     = '0;
    dout_valid = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    unique case (state)
      S_ISSUE: begin
        m_en   = 1'b1;
        m_rd   = 1'b1;
        m_addr = addr;
      end
      S_OUT:   dout_valid = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign m_wr      = 1'b0;
  assign dout_addr = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      rem        <= '0;
      wcnt       <= '0;
      abort_pend <= 1'b0;
      dout_data  <= '0;
    end else begin
      if (state == S_IDLE)
        abort_pend <= 1'b0;
      else if (abort && state != S_DONE)
        abort_pend <= 1'b1;

      unique case (state)
        S_IDLE: if (start) begin
          addr <= base_addr;
          rem  <= length;
        end
        S_ISSUE: wcnt <= W_INIT;
        S_WAIT: begin
          wcnt <= wcnt - W_ONE;
          if (wcnt == W_ONE) dout_data <= m_rdata;
        end
        S_OUT: if (dout_ready) begin
          rem  <= rem - REM_ONE;
          addr <= addr + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Bench for mem_dump_ctrl: memory model with RD_LAT read pipe, per-cycle scoreboard of the byte stream,
// plus directed scenarios with literal timing/data expectations.
module tb_mem_dump_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int RD_LAT = 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } byte_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          dout_ready = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [AW-1:0] m_addr, dout_addr;
  logic [DW-1:0] m_rdata, dout_data;
  logic          m_rd, m_wr, m_en, dout_valid, busy, done;

  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] rd_pipe [RD_LAT];

  byte_t         exp_q [$];
  int            hs_cyc [$];
  logic [DW-1:0] hs_dat [$];
  logic [AW-1:0] hs_adr [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cnt = 0;

  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_dat = '0;
  logic [AW-1:0] hold_adr = '0;

  mem_dump_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
    .abort(abort), .m_addr(m_addr), .m_rdata(m_rdata), .m_rd(m_rd), .m_wr(m_wr),
    .m_en(m_en), .dout_data(dout_data), .dout_addr(dout_addr), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read data appears RD_LAT cycles after the issue cycle; filler otherwise exposes mistimed capture.
  always_ff @(posedge clk) begin
    rd_pipe[0] <= (m_en && m_rd) ? mem[m_addr] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign m_rdata = rd_pipe[RD_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every read must target the next undelivered byte, stream must hold until handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_vld = 1'b0;
      end else begin
        check("m_wr_low", 32'(m_wr), 32'd0);
        check("m_rd_eq_m_en", 32'(m_rd), 32'(m_en));
        if (m_rd) begin
          rd_cnt++;
          if (exp_q.size() == 0) check("read_unexpected", 32'(m_addr), 32'hFFFF_FFFF);
          else                   check("read_addr", 32'(m_addr), 32'(exp_q[0].a));
        end
        if (hold_vld) begin
          check("valid_held", 32'(dout_valid), 32'd1);
          check("data_stable", 32'(dout_data), 32'(hold_dat));
          check("addr_stable", 32'(dout_addr), 32'(hold_adr));
        end
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", 32'(dout_addr), 32'hFFFF_FFFF);
          end else begin
            check("byte_data", 32'(dout_data), 32'(exp_q[0].d));
            check("byte_addr", 32'(dout_addr), 32'(exp_q[0].a));
            void'(exp_q.pop_front());
          end
          hs_cyc.push_back(cyc - start_cyc);
          hs_dat.push_back(dout_data);
          hs_adr.push_back(dout_addr);
        end
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          done_cyc = cyc - start_cyc;
          check("done_after_all", 32'(exp_q.size()), 32'd0);
        end
        hold_vld = dout_valid && !dout_ready;
        hold_dat = dout_data;
        hold_adr = dout_addr;
      end
    end
  end

  task automatic check_zero(input string name);
    check({name, "_addr"}, 32'({m_addr, dout_addr}), 32'd0);
    check({name, "_ctl"}, 32'({dout_data, m_rd, m_wr, m_en, dout_valid, busy, done}), 32'd0);
  endtask

  // Queues the first nexp bytes the dump should deliver, then pulses start; returns at #1 into cycle 1.
  task automatic start_dump(input logic [AW-1:0] base, input logic [AW:0] len, input int nexp);
    logic [AW-1:0] a;
    for (int i = 0; i < nexp; i++) begin
      a = base + AW'(i);
      exp_q.push_back({a, mem[a]});
    end
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
    hs_cyc.delete(); hs_dat.delete(); hs_adr.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = len; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 12'h555; length = 13'd7;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 32'(done_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [AW-1:0] t3_adr [4];
  logic [DW-1:0] t1_dat [3];
  int            t1_cyc [3];

  initial begin
    t3_adr = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    t1_dat = '{8'hAA, 8'hBB, 8'hCC};
    t1_cyc = '{3, 6, 9};
    for (int i = 0; i < (1 << AW); i++) mem[i] = i[7:0] ^ 8'h5A;
    mem[12'h010] = 8'hAA;
    mem[12'h011] = 8'hBB;
    mem[12'h012] = 8'hCC;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;

    // T1: basic three-byte dump, ready always high
    dout_ready = 1'b1;
    start_dump(12'h010, 13'd3, 3);
    wait_done(40);
    check("t1_nbytes", 32'(hs_cyc.size()), 32'd3);
    for (int i = 0; i < 3 && i < hs_cyc.size(); i++) begin
      check("t1_valid_cycle", 32'(hs_cyc[i]), 32'(t1_cyc[i]));
      check("t1_data", 32'(hs_dat[i]), 32'(t1_dat[i]));
      check("t1_addr", 32'(hs_adr[i]), 32'(12'h010 + i));
    end
    check("t1_done_cycle", 32'(done_cyc), 32'd10);
    check("t1_reads", 32'(rd_cnt), 32'd3);
    check("t1_busy_cycles", 32'(busy_cnt), 32'd10);

    // T2: backpressure for five cycles on the first byte
    dout_ready = 1'b0;
    start_dump(12'h020, 13'd2, 2);
    for (int i = 0; i < 20 && !dout_valid; i++) begin
      @(posedge clk); #1;
    end
    check("t2_valid_seen", 32'(dout_valid), 32'd1);
    check("t2_valid_cycle", 32'(cyc - start_cyc), 32'd3);
    repeat (5) @(posedge clk);
    #1;
    check("t2_no_extra_reads", 32'(rd_cnt), 32'd1);
    dout_ready = 1'b1;
    wait_done(40);
    check("t2_first_hs_cycle", (hs_cyc.size() > 0) ? 32'(hs_cyc[0]) : 32'hFFFF_FFFF, 32'd8);
    check("t2_done_cycle", 32'(done_cyc), 32'd12);
    check("t2_reads", 32'(rd_cnt), 32'd2);

    // T3: address wrap at the top of memory
    start_dump(12'hFFE, 13'd4, 4);
    wait_done(60);
    check("t3_nbytes", 32'(hs_adr.size()), 32'd4);
    for (int i = 0; i < 4 && i < hs_adr.size(); i++)
      check("t3_wrap_addr", 32'(hs_adr[i]), 32'(t3_adr[i]));
    check("t3_reads", 32'(rd_cnt), 32'd4);

    // T4: zero-length dump
    start_dump(12'h123, 13'd0, 0);
    wait_done(20);
    check("t4_done_cycle", 32'(done_cyc), 32'd1);
    check("t4_busy_cycles", 32'(busy_cnt), 32'd1);
    check("t4_reads", 32'(rd_cnt), 32'd0);
    check("t4_bytes", 32'(hs_cyc.size()), 32'd0);

    // T5: abort during the WAIT of byte 2 of 5
    start_dump(12'h100, 13'd5, 2);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(40);
    check("t5_bytes", 32'(hs_cyc.size()), 32'd2);
    check("t5_reads", 32'(rd_cnt), 32'd2);
    check("t5_done_cycle", 32'(done_cyc), 32'd7);

    // T6: reset while presenting a byte, then a clean dump that ignores a start while busy
    dout_ready = 1'b0;
    start_dump(12'h200, 13'd3, 3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t6_in_out", 32'(dout_valid), 32'd1);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check_zero("t6_midop_reset");
    dout_ready = 1'b1;
    start_dump(12'h040, 13'd3, 3);
    start = 1'b1; base_addr = 12'h300; length = 13'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40);
    check("t6_bytes", 32'(hs_cyc.size()), 32'd3);
    check("t6_reads", 32'(rd_cnt), 32'd3);
    check("t6_done_cycle", 32'(done_cyc), 32'd10);
    check("t6_last_addr", (hs_adr.size() == 3) ? 32'(hs_adr[2]) : 32'hFFFF_FFFF, 32'h042);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
